// File: rtl/cache_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb_types (package)
// Description : Shared state and requester encodings for the cache/memory
//               line arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package arb_types;

    typedef enum logic [1:0] {
        arb_idle_s   = 2'd0,
        arb_icache_s = 2'd1,
        arb_dcache_s = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_ICACHE = 1'b0,
        REQ_DCACHE = 1'b1
    } requester_t;

endpackage
`default_nettype wire

// File: rtl/cache_mem_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick2
// Description : Combinational two-way round-robin select. On a tie the
//               requester that did not win last time is chosen.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick2 (
    input  logic i_req_i,
    input  logic i_req_d,
    input  logic i_last_d,
    output logic o_valid,
    output logic o_pick_d
);

    always_comb begin
        o_valid  = i_req_i | i_req_d;
        o_pick_d = 1'b0;
        if (i_req_i && i_req_d) begin
            o_pick_d = ~i_last_d;
        end else if (i_req_d) begin
            o_pick_d = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_mem_arbiter
// Description : Shares one line-wide memory port between the icache and the
//               dcache, one line transaction at a time, round-robin on ties.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_mem_arbiter
    import arb_types::*;
#(
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_read,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,

    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,

    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp
);

    arb_state_t r_state;
    requester_t r_last_grant;

    logic w_grant_valid;
    logic w_grant_d;

    rr_pick2 u_pick (
        .i_req_i  (i_read),
        .i_req_d  (d_read | d_write),
        .i_last_d (r_last_grant == REQ_DCACHE),
        .o_valid  (w_grant_valid),
        .o_pick_d (w_grant_d)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= arb_idle_s;
            r_last_grant <= REQ_DCACHE;
            mem_addr     <= '0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_wdata    <= '0;
        end else begin
            case (r_state)
                arb_idle_s: begin
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    if (w_grant_valid) begin
                        if (w_grant_d) begin
                            r_state      <= arb_dcache_s;
                            r_last_grant <= REQ_DCACHE;
                            mem_addr     <= d_addr;
                            // An illegal read+write request is served as the writeback.
                            mem_read     <= ~d_write;
                            mem_write    <= d_write;
                            if (d_write) begin
                                mem_wdata <= d_wdata;
                            end
                        end else begin
                            r_state      <= arb_icache_s;
                            r_last_grant <= REQ_ICACHE;
                            mem_addr     <= i_addr;
                            mem_read     <= 1'b1;
                            mem_write    <= 1'b0;
                        end
                    end
                end
                arb_icache_s, arb_dcache_s: begin
                    if (mem_resp) begin
                        r_state   <= arb_idle_s;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= arb_idle_s;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                end
            endcase
        end
    end

    // Completion is routed straight from memory so the cache sees it in the same cycle.
    assign i_resp  = (r_state == arb_icache_s) && mem_resp;
    assign d_resp  = (r_state == arb_dcache_s) && mem_resp;
    assign i_rdata = i_resp ? mem_rdata : {LINE_WIDTH{1'bx}};
    assign d_rdata = d_resp ? mem_rdata : {LINE_WIDTH{1'bx}};

    a_dcache_rw_exclusive: assert property (@(posedge clk) disable iff (!rst)
        !(d_read && d_write));
    a_no_resp_in_idle: assert property (@(posedge clk) disable iff (!rst)
        !(mem_resp && (r_state == arb_idle_s)));

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_mem_arbiter
// Description : Self-checking bench: directed vectors, corner sequences and a
//               randomized run against a transaction-level arbitration model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_mem_arbiter;

    localparam int LW = 256;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] i_addr = '0, d_addr = '0, mem_addr;
    logic          i_read = 1'b0, d_read = 1'b0, d_write = 1'b0;
    logic          i_resp, d_resp, mem_read, mem_write;
    logic          mem_resp = 1'b0;
    logic [LW-1:0] i_rdata, d_rdata, mem_wdata;
    logic [LW-1:0] d_wdata = '0, mem_rdata = '0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cache_mem_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    // Memory: answers after a fixed or random number of busy cycles, reset with rst.
    int            fixed_lat = 0;
    logic          use_fixed_rd = 1'b0;
    logic [LW-1:0] fixed_rd = '0;
    int            mcnt = 0;
    int            mlat = 1;
    logic          mrst;

    always @(posedge clk) begin
        mrst = rst;
        #2;
        if (!mrst) begin
            mcnt = 0; mem_resp = 1'b0; mem_rdata = '0;
        end else if (mem_resp) begin
            mcnt = 0; mem_resp = 1'b0; mem_rdata = '0;
        end else if (mem_read || mem_write) begin
            if (mcnt == 0) mlat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 5));
            mcnt++;
            if (mcnt >= mlat) begin
                mem_resp = 1'b1;
                if (use_fixed_rd) mem_rdata = fixed_rd;
                else for (int k = 0; k < 8; k++) mem_rdata[k*32 +: 32] = $urandom;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nedge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b0; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic wait_start(input string nm);
        int n = 0;
        nedge();
        while (!(mem_read || mem_write) && n < 20) begin
            nedge();
            n++;
        end
        chk(nm, mem_read || mem_write, 1'b1);
    endtask

    task automatic wait_resp(input string nm);
        int n = 0;
        while (!mem_resp && n < 20) begin
            nedge();
            n++;
        end
        chk(nm, mem_resp, 1'b1);
    endtask

    typedef struct {
        logic          is_d;
        logic          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
        logic [LW-1:0] rdata;
        int            lat;
        logic [AW-1:0] e_addr;
        logic          e_rd;
        logic          e_wr;
        logic [LW-1:0] e_wdata;
        logic          e_ir;
        logic          e_dr;
        logic [LW-1:0] e_rdata;
    } vec_t;

    vec_t tbl[4];

    // Random-phase model state
    int   igap, dgap;
    logic idone, ddone;
    logic prev_busy, prev_i, prev_d, prev_resp;
    logic last_d, cur_d, g_d, busy;
    logic [AW-1:0] e_addr;
    logic          e_wr;
    logic [LW-1:0] e_wdata;

    initial begin
        tbl[0] = '{1'b0, 1'b0, 32'h0000_1040, '0, {32{8'hA5}}, 4,
                   32'h0000_1040, 1'b1, 1'b0, '0, 1'b1, 1'b0, {32{8'hA5}}};
        tbl[1] = '{1'b1, 1'b0, 32'h8000_0040, '0, {32{8'h5A}}, 1,
                   32'h8000_0040, 1'b1, 1'b0, '0, 1'b0, 1'b1, {32{8'h5A}}};
        tbl[2] = '{1'b1, 1'b1, 32'h8000_0060, {16{16'h1234}}, '0, 2,
                   32'h8000_0060, 1'b0, 1'b1, {16{16'h1234}}, 1'b0, 1'b1, '0};
        tbl[3] = '{1'b0, 1'b0, 32'hFFFF_FFE0, '0, {LW{1'b1}}, 3,
                   32'hFFFF_FFE0, 1'b1, 1'b0, '0, 1'b1, 1'b0, {LW{1'b1}}};

        // Reset and quiet idle
        tick();
        tick();
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            nedge();
            chk("reset_idle", {mem_read, mem_write, i_resp, d_resp}, 4'b0000);
        end
        chk("reset_addr", mem_addr, 32'h0);
        chk("reset_wdata", mem_wdata, '0);

        // Single-transaction vectors
        use_fixed_rd = 1'b1;
        for (int v = 0; v < 4; v++) begin
            fixed_lat = tbl[v].lat;
            fixed_rd  = tbl[v].rdata;
            tick();
            if (tbl[v].is_d) begin
                d_addr = tbl[v].addr; d_read = !tbl[v].wr; d_write = tbl[v].wr;
                d_wdata = tbl[v].wdata;
            end else begin
                i_addr = tbl[v].addr; i_read = 1'b1;
            end
            nedge();
            chk("vec_not_yet", {mem_read, mem_write}, 2'b00);
            nedge();
            chk("vec_addr", mem_addr, tbl[v].e_addr);
            chk("vec_dir", {mem_read, mem_write}, {tbl[v].e_rd, tbl[v].e_wr});
            if (tbl[v].e_wr) chk("vec_wdata", mem_wdata, tbl[v].e_wdata);
            wait_resp("vec_mem_resp");
            chk("vec_resp", {i_resp, d_resp}, {tbl[v].e_ir, tbl[v].e_dr});
            if (!tbl[v].wr) chk("vec_rdata", tbl[v].is_d ? d_rdata : i_rdata, tbl[v].e_rdata);
            tick();
            i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
            nedge();
            chk("vec_back_idle", {mem_read, mem_write, i_resp, d_resp}, 4'b0000);
        end

        // Writeback then icache read one cycle later
        fixed_lat = 3;
        fixed_rd  = {32{8'h3C}};
        tick();
        d_write = 1'b1; d_addr = 32'h8000_0020; d_wdata = {16{16'h1234}};
        tick();
        i_read = 1'b1; i_addr = 32'h0000_2000;
        nedge();
        chk("wb_dir", {mem_read, mem_write}, 2'b01);
        chk("wb_addr", mem_addr, 32'h8000_0020);
        chk("wb_wdata", mem_wdata, {16{16'h1234}});
        wait_resp("wb_mem_resp");
        chk("wb_resp", {i_resp, d_resp}, 2'b01);
        tick();
        d_write = 1'b0;
        nedge();
        chk("wb_gap_idle", {mem_read, mem_write}, 2'b00);
        nedge();
        chk("wb_then_i_dir", {mem_read, mem_write}, 2'b10);
        chk("wb_then_i_addr", mem_addr, 32'h0000_2000);
        wait_resp("wb_i_mem_resp");
        chk("wb_i_resp", {i_resp, d_resp}, 2'b10);
        chk("wb_i_rdata", i_rdata, {32{8'h3C}});
        tick();
        i_read = 1'b0;

        // Simultaneous held requests alternate I, D, I, D
        do_reset();
        fixed_lat = 2;
        i_read = 1'b1; i_addr = 32'h0000_0100;
        d_read = 1'b1; d_addr = 32'h8000_0100;
        for (int g = 0; g < 4; g++) begin
            wait_start("rr_start");
            chk("rr_order", mem_addr, (g % 2 == 0) ? 32'h0000_0100 : 32'h8000_0100);
            wait_resp("rr_mem_resp");
            chk("rr_resp", {i_resp, d_resp}, (g % 2 == 0) ? 2'b10 : 2'b01);
        end
        tick();
        i_read = 1'b0; d_read = 1'b0;
        nedge();
        nedge();
        chk("rr_done_idle", {mem_read, mem_write}, 2'b00);

        // Address change during an active icache grant is ignored
        fixed_lat = 5;
        tick();
        i_read = 1'b1; i_addr = 32'h0000_3000;
        nedge();
        nedge();
        chk("hold_first", mem_addr, 32'h0000_3000);
        tick();
        i_addr = 32'h0000_4000;
        for (int n = 0; n < 10; n++) begin
            nedge();
            chk("hold_addr", mem_addr, 32'h0000_3000);
            if (mem_resp) break;
        end
        chk("hold_resp", i_resp, 1'b1);
        tick();
        i_read = 1'b0;

        // Reset during an active dcache read
        fixed_lat = 5;
        tick();
        d_read = 1'b1; d_addr = 32'h8000_0100;
        nedge();
        nedge();
        chk("rstmid_busy", mem_read, 1'b1);
        tick();
        tick();
        rst = 1'b0; d_read = 1'b0;
        nedge();
        chk("rstmid_no_resp0", d_resp, 1'b0);
        nedge();
        chk("rstmid_cleared", {mem_read, mem_write, d_resp}, 3'b000);
        tick();
        rst = 1'b1;
        fixed_lat = 2;
        fixed_rd  = {8{32'hDEAD_BEEF}};
        tick();
        d_read = 1'b1; d_addr = 32'h8000_0200;
        nedge();
        nedge();
        chk("rstmid_new_dir", {mem_read, mem_write}, 2'b10);
        chk("rstmid_new_addr", mem_addr, 32'h8000_0200);
        wait_resp("rstmid_new_mem_resp");
        chk("rstmid_new_resp", {i_resp, d_resp}, 2'b01);
        chk("rstmid_new_rdata", d_rdata, {8{32'hDEAD_BEEF}});
        tick();
        d_read = 1'b0;

        // Randomized traffic against the arbitration model
        do_reset();
        fixed_lat = 0;
        use_fixed_rd = 1'b0;
        igap = $urandom_range(0, 2); dgap = $urandom_range(0, 2);
        idone = 1'b0; ddone = 1'b0;
        prev_busy = 1'b0; prev_i = 1'b0; prev_d = 1'b0; prev_resp = 1'b0;
        last_d = 1'b1; cur_d = 1'b0;
        e_addr = '0; e_wr = 1'b0; e_wdata = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            tick();
            if (idone) begin
                i_read = 1'b0; idone = 1'b0; igap = $urandom_range(1, 4);
            end else if (!i_read) begin
                if (igap == 0) begin
                    i_read = 1'b1; i_addr = $urandom & 32'hFFFF_FFE0;
                end else igap--;
            end
            if (ddone) begin
                d_read = 1'b0; d_write = 1'b0; ddone = 1'b0; dgap = $urandom_range(1, 4);
            end else if (!(d_read || d_write)) begin
                if (dgap == 0) begin
                    d_write = $urandom_range(0, 1);
                    d_read  = !d_write;
                    d_addr  = $urandom & 32'hFFFF_FFE0;
                    for (int k = 0; k < 8; k++) d_wdata[k*32 +: 32] = $urandom;
                end else dgap--;
            end

            nedge();
            busy = mem_read || mem_write;
            if (prev_resp) chk("rnd_idle_after_resp", busy, 1'b0);
            chk("rnd_start", busy && !prev_busy, !prev_busy && (prev_i || prev_d));
            if (busy && !prev_busy) begin
                g_d    = (prev_i && prev_d) ? !last_d : prev_d;
                last_d = g_d;
                cur_d  = g_d;
                e_addr = g_d ? d_addr : i_addr;
                e_wr   = g_d ? d_write : 1'b0;
                e_wdata = d_wdata;
                chk("rnd_grant_addr", mem_addr, e_addr);
                chk("rnd_grant_dir", {mem_read, mem_write}, {!e_wr, e_wr});
                if (e_wr) chk("rnd_grant_wdata", mem_wdata, e_wdata);
            end else if (busy) begin
                chk("rnd_hold", {mem_read, mem_write, mem_addr}, {!e_wr, e_wr, e_addr});
            end
            chk("rnd_resp", {i_resp, d_resp},
                {busy && mem_resp && !cur_d, busy && mem_resp && cur_d});
            if (busy && mem_resp && !cur_d) begin
                chk("rnd_i_rdata", i_rdata, mem_rdata);
                idone = 1'b1;
            end
            if (busy && mem_resp && cur_d) begin
                if (!e_wr) chk("rnd_d_rdata", d_rdata, mem_rdata);
                ddone = 1'b1;
            end
            prev_busy = busy;
            prev_i    = i_read;
            prev_d    = d_read || d_write;
            prev_resp = busy && mem_resp;
        end
        tick();
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        repeat (8) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single 256-bit line-wide memory port between the instruction cache (read-only) and the data cache (read, plus dirty-line writeback).
- Sits between the two cache dfp ports and the memory/burst interface.
- Grants one line transaction at a time. Simultaneous requests use round-robin priority.
- Registers all memory-side outputs and routes the response and line data back to the granted cache.

Parameters:
- LINE_WIDTH, 256, cache line width in bits (mem_rdata, mem_wdata, i_rdata, d_rdata, d_wdata).
- ADDR_WIDTH, 32, byte address width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- i_addr  in  ADDR_WIDTH  icache line address, 32-byte aligned.
- i_read  in  1  icache line read request; held high until i_resp.
- i_rdata  out  LINE_WIDTH  line returned to icache.
- i_resp  out  1  icache transaction complete.
- d_addr  in  ADDR_WIDTH  dcache line address, 32-byte aligned.
- d_read  in  1  dcache line read request; held until d_resp.
- d_write  in  1  dcache line writeback request; held until d_resp.
- d_wdata  in  LINE_WIDTH  writeback line.
- d_rdata  out  LINE_WIDTH  line returned to dcache.
- d_resp  out  1  dcache transaction complete.
- mem_addr  out  ADDR_WIDTH  memory address, registered.
- mem_read  out  1  memory read, registered.
- mem_write  out  1  memory write, registered.
- mem_wdata  out  LINE_WIDTH  memory write line, registered.
- mem_rdata  in  LINE_WIDTH  memory read line, valid with mem_resp.
- mem_resp  in  1  memory transaction complete, single-cycle pulse.

Behaviour:
- FSM states: ARB_IDLE, ARB_ICACHE, ARB_DCACHE.
- Reset (rst==0 at a clock edge):
  - state goes to ARB_IDLE.
  - mem_read = mem_write = 0; mem_addr and mem_wdata = 0.
  - last_grant = DCACHE, so the first tie goes to icache.
  - i_resp = d_resp = 0.
- Reset mid-transaction abandons the transaction. Memory is reset on the same rst.
- ARB_IDLE: memory outputs deasserted. Requests are sampled each cycle.
  - Only i_read high -> ARB_ICACHE.
  - Only d_read or d_write high -> ARB_DCACHE.
  - Both high -> grant the requester that is NOT last_grant.
  - On the granting edge: latch address, direction and (dcache write) d_wdata into the mem_* registers; update last_grant.
  - mem_read/mem_write are therefore high from the cycle after the request is sampled.
- ARB_ICACHE / ARB_DCACHE:
  - mem_* held constant; requester inputs ignored after the latch.
  - On mem_resp: the granted resp is asserted combinationally in the same cycle, and the granted rdata = mem_rdata in that cycle.
  - On the next edge: state goes to ARB_IDLE and mem_read/mem_write clear.
- The non-granted resp is always 0. i_rdata/d_rdata are undriven ('x) when their resp is 0.
- Latency: minimum request-to-mem_read is 1 cycle. Back-to-back grants have exactly one ARB_IDLE cycle between them.
- Requester contract: drop or change the request in the cycle after resp, otherwise it is re-arbitrated as a new request.
- A mem_resp in ARB_IDLE is a protocol error: ignored, flagged by assertion.
- d_read and d_write both high is illegal (assertion). If it occurs, write wins.
- Starvation: with both requesters continuously asserting, grants alternate I, D, I, D.
- No write buffering. Dcache writeback and its following allocate read are two separate grants; icache may be granted between them.

Decomposition:
- Shared package arb_types:
  - arb_state_t enum {arb_idle_s, arb_icache_s, arb_dcache_s}.
  - requester_t enum {REQ_ICACHE, REQ_DCACHE}.
- Optional sub-module rr_pick2: combinational 2-way round-robin select from request vector plus last_grant.
- All registers live in cache_mem_arbiter.

Test Plan:
1. Reset (rst=0 two cycles), no requests -> mem_read=mem_write=0, i_resp=d_resp=0; state idle for 10 cycles.
2. i_read=1, i_addr=0x0000_1040 alone; memory responds 4 cycles later with 0xA5…A5 -> mem_read=1, mem_addr=0x1040 from next cycle; i_resp=1 with i_rdata=0xA5…A5 in the mem_resp cycle; d_resp stays 0.
3. d_write=1, d_addr=0x8000_0020, d_wdata=0x1234…; i_read asserted 1 cycle later -> dcache granted, mem_write=1, mem_wdata=0x1234…; after d_resp, one idle cycle, then mem_read for the icache address.
4. i_read and d_read asserted in the same cycle after reset -> icache granted first, then dcache. Hold both continuously for 4 transactions -> grant order I, D, I, D.
5. Change i_addr while ARB_ICACHE is active -> mem_addr stays at the latched value until mem_resp.
6. Drive rst=0 during an active dcache read (before mem_resp) -> next edge mem_read=0, state ARB_IDLE, no d_resp; a new request after reset completes normally.
